charge_meter: RTL and testbench

//   Upstream measurement stage of the bisection current-reference loop.

---
 rtl/charge_meter_pkg.sv | 23 ++
 rtl/charge_accum.sv | 56 +++++
 rtl/charge_meter.sv | 136 +++++++++++++
 tb/tb_charge_meter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/charge_meter_pkg.sv
// Shared control definitions for the charge measurement stage.
// Holds the FSM state encoding, default widths and the accumulator width formula.
// No logic; imported by charge_meter and charge_accum.
package charge_meter_pkg;

    // Defaults shared with the bisection controller.
    localparam int DEF_BUS_WIDTH     = 10;
    localparam int DEF_WINDOW_LOG2   = 4;
    localparam int DEF_SETTLE_CYCLES = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DONE   = 2'd3
    } cm_state_t;

    // A sum of 2^wl unsigned bw-bit samples always fits in bw+wl bits.
    function automatic int acc_width(input int bw, input int wl);
        return bw + wl;
    endfunction

endpackage

// File: rtl/charge_accum.sv
// Window accumulator: sums valid samples and counts them, flagging the last slot of the window.
// Latency: sum/count update one cycle after add; sum_nxt and window_done are combinational views.
// Backpressure: none; every add is absorbed. clr has priority over add.
// Ports: clk, rst_n; clr (zero sum and count), add (take sample), sample (BUS_WIDTH);
//        mean_nxt = upper BUS_WIDTH bits of (acc + sample); window_done = next add completes the window.
module charge_accum
    import charge_meter_pkg::*;
#(
    parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int WINDOW_LOG2 = DEF_WINDOW_LOG2   // must be >= 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 add,
    input  logic [BUS_WIDTH-1:0] sample,
    output logic [BUS_WIDTH-1:0] mean_nxt,
    output logic                 window_done
);

    localparam int ACC_W = acc_width(BUS_WIDTH, WINDOW_LOG2);

    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [WINDOW_LOG2-1:0] smp_cnt_q, smp_cnt_d;
    logic [ACC_W-1:0]       sum_nxt;

    // Sum including the sample currently presented; used both as the next
    // accumulator value and for the mean on the window's final sample.
    assign sum_nxt     = acc_q + ACC_W'(sample);
    assign mean_nxt    = sum_nxt[ACC_W-1:WINDOW_LOG2];
    // Counter sits at N-1 once N-1 samples are in: the next add is the last one.
    assign window_done = (smp_cnt_q == {WINDOW_LOG2{1'b1}});

    always_comb begin
        acc_d     = acc_q;
        smp_cnt_d = smp_cnt_q;
        if (clr) begin
            acc_d     = '0;
            smp_cnt_d = '0;
        end else if (add) begin
            acc_d     = sum_nxt;
            smp_cnt_d = smp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            smp_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            smp_cnt_q <= smp_cnt_d;
        end
    end

endmodule

// File: rtl/charge_meter.sv
// Charge meter: waits for the analog path to settle after an i_ref change, averages a sample window, removes an offset.
// Latency: 1 + SETTLE_CYCLES + 2^WINDOW_LOG2 cycles from i_ref change to ready with continuous sample_valid.
// Backpressure: none; sample_valid gaps only stretch the window, an i_ref change restarts the measurement.
// Ports: clk, rst_n (async, active low); enable; i_ref; sample_valid/sample; q_offset;
//        q_measured (registered mean - offset, floored at 0), ready (DONE only), busy (SETTLE or ACCUM).
module charge_meter
    import charge_meter_pkg::*;
#(
    parameter int BUS_WIDTH     = DEF_BUS_WIDTH,
    parameter int WINDOW_LOG2   = DEF_WINDOW_LOG2,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES   // must be >= 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 sample_valid,
    input  logic [BUS_WIDTH-1:0] sample,
    input  logic [BUS_WIDTH-1:0] q_offset,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy
);

    localparam int               SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    cm_state_t              state_q, state_d;
    logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
    logic [BUS_WIDTH-1:0]   i_ref_q;
    logic [BUS_WIDTH-1:0]   q_measured_q, q_measured_d;
    logic                   ready_q, ready_d;

    logic                   ref_chg;
    logic                   acc_clr;
    logic                   acc_add;
    logic [BUS_WIDTH-1:0]   mean_nxt;
    logic                   window_done;
    logic [BUS_WIDTH:0]     diff;
    logic [BUS_WIDTH-1:0]   q_sat;

    assign ref_chg = (i_ref != i_ref_q);

    // One extra bit catches the borrow: a set MSB means offset exceeded the mean.
    assign diff  = {1'b0, mean_nxt} - {1'b0, q_offset};
    assign q_sat = diff[BUS_WIDTH] ? '0 : diff[BUS_WIDTH-1:0];

    charge_accum #(
        .BUS_WIDTH   (BUS_WIDTH),
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (acc_clr),
        .add         (acc_add),
        .sample      (sample),
        .mean_nxt    (mean_nxt),
        .window_done (window_done)
    );

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        q_measured_d = q_measured_q;
        acc_clr      = 1'b0;
        acc_add      = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            acc_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
                ST_SETTLE: begin
                    if (ref_chg) begin
                        settle_cnt_d = '0;
                    end else if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = ST_ACCUM;
                        acc_clr = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    // A reference change wins over a coincident final sample:
                    // that window belongs to the old i_ref and is thrown away.
                    if (ref_chg) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                        acc_clr      = 1'b1;
                    end else if (sample_valid) begin
                        acc_add = 1'b1;
                        if (window_done) begin
                            state_d      = ST_DONE;
                            q_measured_d = q_sat;
                        end
                    end
                end
                ST_DONE: begin
                    if (ref_chg) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Registered alongside the state so ready drops on the very edge a change is seen.
        ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            i_ref_q      <= '0;
            q_measured_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            i_ref_q      <= i_ref;
            q_measured_q <= q_measured_d;
            ready_q      <= ready_d;
        end
    end

    assign q_measured = q_measured_q;
    assign ready      = ready_q;
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_ACCUM);

endmodule

// File: tb/tb_charge_meter.sv
// Testbench for charge_meter: directed scenarios plus random traffic against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_charge_meter;

    localparam int BW = 10;
    localparam int WL = 4;
    localparam int SC = 8;
    localparam int N  = 1 << WL;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [BW-1:0] i_ref;
    logic          sample_valid;
    logic [BW-1:0] sample;
    logic [BW-1:0] q_offset;
    logic [BW-1:0] q_measured;
    logic          ready;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    charge_meter #(
        .BUS_WIDTH     (BW),
        .WINDOW_LOG2   (WL),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .i_ref        (i_ref),
        .sample_valid (sample_valid),
        .sample       (sample),
        .q_offset     (q_offset),
        .q_measured   (q_measured),
        .ready        (ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Mode: 0 idle, 1 waiting for settle, 2 collecting window, 3 result held.
    int            m_mode;
    int            m_wait;
    int            m_win[$];
    int            m_q;
    logic [BW-1:0] m_prev_ref;

    task automatic model_reset();
        m_mode     = 0;
        m_wait     = 0;
        m_win.delete();
        m_q        = 0;
        m_prev_ref = '0;
    endtask

    task automatic model_step();
        bit chg;
        int sum;
        int mean;
        chg = (i_ref != m_prev_ref);
        if (!enable) begin
            m_mode = 0;
            m_win.delete();
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_wait = 0; end
                1: begin
                    if (chg) m_wait = 0;
                    else if (m_wait == SC - 1) begin m_mode = 2; m_win.delete(); end
                    else m_wait++;
                end
                2: begin
                    if (chg) begin
                        m_mode = 1; m_wait = 0; m_win.delete();
                    end else if (sample_valid) begin
                        m_win.push_back(int'(sample));
                        if (m_win.size() == N) begin
                            sum = 0;
                            foreach (m_win[k]) sum += m_win[k];
                            mean = sum / N;
                            m_q  = (mean > int'(q_offset)) ? mean - int'(q_offset) : 0;
                            m_mode = 3;
                        end
                    end
                end
                default: begin
                    if (chg) begin m_mode = 1; m_wait = 0; end
                end
            endcase
        end
        m_prev_ref = i_ref;
    endtask

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, DUT compared at the following falling edge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        check("ready", int'(ready), (m_mode == 3) ? 1 : 0);
        check("busy",  int'(busy),  (m_mode == 1 || m_mode == 2) ? 1 : 0);
        check("q_measured", int'(q_measured), m_q);
    endtask

    // Clock until DUT ready rises; n = edges taken, or max+1 on timeout.
    task automatic wait_ready(input int max, output int n);
        n = 0;
        while (n <= max) begin
            cyc();
            n++;
            if (ready === 1'b1) return;
        end
    endtask

    int n;

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        i_ref        = '0;
        sample_valid = 1'b0;
        sample       = '0;
        q_offset     = '0;
        model_reset();
        #3;
        check("reset_q", int'(q_measured), 0);
        check("reset_ready", int'(ready), 0);
        check("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant samples, no offset: 25 edges to ready, mean 300.
        enable = 1'b1; i_ref = 10'd512; sample = 10'd300; sample_valid = 1'b1; q_offset = '0;
        wait_ready(40, n);
        check("lat_first", n, 25);
        check("mean_300", int'(q_measured), 300);

        // Change while in DONE: ready drops on the detect edge, q holds.
        i_ref = 10'd256; q_offset = 10'd400;
        cyc();
        check("done_chg_ready", int'(ready), 0);
        check("done_chg_busy", int'(busy), 1);
        check("done_chg_qhold", int'(q_measured), 300);
        // Offset larger than mean floors to zero.
        wait_ready(40, n);
        check("lat_after_chg", n, 24);
        check("floor_q", int'(q_measured), 0);
        check("floor_ready", int'(ready), 1);

        // Change coincident with the 16th valid sample discards that window.
        q_offset = '0; i_ref = 10'd512;
        repeat (24) cyc();
        check("pre16_busy", int'(busy), 1);
        i_ref = 10'd256; sample = 10'd200;
        cyc();
        check("abort_ready", int'(ready), 0);
        wait_ready(40, n);
        check("lat_abort", n, 24);
        check("mean_200", int'(q_measured), 200);

        // Alternating valid with samples 0..15: mean 7.
        i_ref = 10'd300; sample_valid = 1'b0;
        repeat (9) cyc();
        for (int k = 0; k < N; k++) begin
            sample_valid = 1'b1; sample = BW'(k);
            cyc();
            sample_valid = 1'b0;
            cyc();
        end
        check("gap_ready", int'(ready), 1);
        check("gap_mean", int'(q_measured), 7);

        // Asynchronous reset in the middle of a window.
        i_ref = 10'd400; sample = 10'd500; sample_valid = 1'b1;
        repeat (14) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("arst_q", int'(q_measured), 0);
        check("arst_ready", int'(ready), 0);
        check("arst_busy", int'(busy), 0);
        model_reset();
        enable = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("idle_after_rst", int'(busy), 0);
        enable = 1'b1;
        cyc();
        check("settle_after_en", int'(busy), 1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            enable       = ($urandom_range(99) >= 2);
            if ($urandom_range(99) < 2) i_ref = BW'($urandom);
            sample_valid = ($urandom_range(99) < 75);
            sample       = BW'($urandom);
            q_offset     = ($urandom_range(3) == 0) ? BW'($urandom) : BW'($urandom_range(200));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
